// File: rtl/crossbar_burst_allocator_pkg.sv
// rtl/crossbar_burst_allocator_pkg.sv - shared sizes, FSM state type and command-bit indexing
package xbar_alloc_pkg;

  localparam int NUM_INPUT_DATA  = 16;
  localparam int NUM_OUTPUT_DATA = 8;
  localparam int DEST_W          = $clog2(NUM_OUTPUT_DATA);
  localparam int IDX_W           = $clog2(NUM_INPUT_DATA);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } out_state_e;

  // Position of the crossbar command bit routing input j to output o.
  function automatic int cmd_idx(input int j, input int o);
    return j * NUM_OUTPUT_DATA + o;
  endfunction

endpackage

// File: rtl/crossbar_burst_allocator_if.sv
// rtl/crossbar_burst_allocator_if.sv - requester/crossbar-side bundle of the burst allocator
interface crossbar_burst_allocator_if;
  import xbar_alloc_pkg::*;

  logic [NUM_INPUT_DATA-1:0]                 i_req;
  logic [NUM_INPUT_DATA*DEST_W-1:0]          i_dest;
  logic [NUM_INPUT_DATA-1:0]                 i_last;
  logic [NUM_INPUT_DATA-1:0]                 o_grant;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd;
  logic                                      o_en;
  logic [NUM_OUTPUT_DATA-1:0]                o_busy;

  // Requesters drive the request side and observe grants and crossbar commands.
  modport master (
    output i_req, i_dest, i_last,
    input  o_grant, o_cmd, o_en, o_busy
  );

  // The allocator consumes requests and produces grants and crossbar commands.
  modport slave (
    input  i_req, i_dest, i_last,
    output o_grant, o_cmd, o_en, o_busy
  );

endinterface

// File: rtl/crossbar_burst_allocator_rr_arbiter.sv
// rtl/crossbar_burst_allocator_rr_arbiter.sv - 16-way round-robin pick starting at a pointer
module rr_arbiter_16
  import xbar_alloc_pkg::*;
(
  input  logic [NUM_INPUT_DATA-1:0] req,
  input  logic [IDX_W-1:0]          ptr,
  output logic [NUM_INPUT_DATA-1:0] gnt,
  output logic [IDX_W-1:0]          idx,
  output logic                      valid
);

  logic [IDX_W-1:0] probe;

  // Scan upward from ptr, wrapping naturally through the 4-bit index, and keep the first request.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    probe = '0;
    for (int k = 0; k < NUM_INPUT_DATA; k++) begin
      probe = ptr + IDX_W'(k);
      if (!valid && req[probe]) begin
        valid = 1'b1;
        idx   = probe;
      end
    end
    gnt = valid ? (NUM_INPUT_DATA'(1) << idx) : '0;
  end

endmodule

// File: rtl/crossbar_burst_allocator.sv
// rtl/crossbar_burst_allocator.sv - per-output burst ownership FSMs driving the one-hot crossbar
module crossbar_burst_allocator
  import xbar_alloc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  crossbar_burst_allocator_if.slave bus
);

  logic [NUM_OUTPUT_DATA-1:0][NUM_INPUT_DATA-1:0] cand;
  logic [NUM_OUTPUT_DATA-1:0][NUM_INPUT_DATA-1:0] col;
  logic [NUM_OUTPUT_DATA-1:0]                     busy;
  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0]      cmd;
  logic [NUM_INPUT_DATA-1:0]                      owns;
  logic [NUM_INPUT_DATA-1:0]                      grant;
  logic                                           en;

  // An input that already owns an output must not compete for another one.
  for (genvar j = 0; j < NUM_INPUT_DATA; j++) begin : g_row
    assign owns[j] = |cmd[cmd_idx(j, 0) +: NUM_OUTPUT_DATA];
  end

  // A beat transfers only while its requester owns an output and still requests.
  assign grant = owns & bus.i_req;

  for (genvar o = 0; o < NUM_OUTPUT_DATA; o++) begin : g_out
    out_state_e              state, state_nxt;
    logic [IDX_W-1:0]          own, own_nxt, ptr, ptr_nxt, arb_idx;
    logic [NUM_INPUT_DATA-1:0] col_q, col_nxt, arb_gnt;
    logic                      arb_valid;

    for (genvar j = 0; j < NUM_INPUT_DATA; j++) begin : g_in
      assign cand[o][j] = bus.i_req[j] && !owns[j] &&
                          (bus.i_dest[j*DEST_W +: DEST_W] == DEST_W'(o));
      assign cmd[cmd_idx(j, o)] = col[o][j];
    end

    rr_arbiter_16 u_arb (
      .req   (cand[o]),
      .ptr   (ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
    );

    // Claim the output for the round-robin winner, release it after the owner's last granted beat.
    always_comb begin
      state_nxt = state;
      own_nxt   = own;
      ptr_nxt   = ptr;
      col_nxt   = col_q;
      if (state == IDLE) begin
        if (arb_valid) begin
          state_nxt = BUSY;
          own_nxt   = arb_idx;
          ptr_nxt   = arb_idx + 1'b1;
          col_nxt   = arb_gnt;
        end
      end else if (grant[own] && bus.i_last[own]) begin
        state_nxt = IDLE;
        col_nxt   = '0;
      end
    end

    // Ownership state; the one-hot column is the registered crossbar command for this output.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        own   <= '0;
        ptr   <= '0;
        col_q <= '0;
      end else begin
        state <= state_nxt;
        own   <= own_nxt;
        ptr   <= ptr_nxt;
        col_q <= col_nxt;
      end
    end

    assign col[o]  = col_q;
    assign busy[o] = (state == BUSY);
  end

  // Crossbar enable comes up on the first edge after reset release and stays up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en <= 1'b0;
    else     en <= 1'b1;
  end

  assign bus.o_cmd   = cmd;
  assign bus.o_grant = grant;
  assign bus.o_busy  = busy;
  assign bus.o_en    = en;

endmodule

// File: tb/tb_crossbar_burst_allocator.sv
// tb/tb_crossbar_burst_allocator.sv - self-checking bench for the crossbar burst allocator
module tb_crossbar_burst_allocator;
  import xbar_alloc_pkg::*;

  localparam int NI = NUM_INPUT_DATA;
  localparam int NO = NUM_OUTPUT_DATA;

  logic clk = 1'b0;
  logic rst = 1'b1;

  crossbar_burst_allocator_if bus ();

  crossbar_burst_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: owner per output (-1 = free) and the next-preferred input per output.
  int m_own [NO];
  int m_ptr [NO];
  bit m_en;

  logic [NI-1:0]    e_grant;
  logic [NI*NO-1:0] e_cmd;
  logic [NO-1:0]    e_busy;

  typedef struct {
    logic [NI-1:0]        req;
    logic [NI*DEST_W-1:0] dest;
    logic [NI-1:0]        last;
    logic [NI-1:0]        exp_grant;
    logic [NO-1:0]        exp_busy;
  } vec_t;

  vec_t tbl[$];

  bit   r_act  [NI];
  int   r_dest [NI];
  int   r_left [NI];

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NI*DEST_W-1:0] dpos(input int j, input int d);
    logic [NI*DEST_W-1:0] v;
    v = (NI*DEST_W)'(d);
    return v << (j * DEST_W);
  endfunction

  function automatic vec_t mk(input logic [NI-1:0] req, input logic [NI*DEST_W-1:0] dest,
                              input logic [NI-1:0] last, input logic [NI-1:0] g, input logic [NO-1:0] b);
    vec_t v;
    v.req = req; v.dest = dest; v.last = last; v.exp_grant = g; v.exp_busy = b;
    return v;
  endfunction

  task automatic drive(input logic [NI-1:0] req, input logic [NI*DEST_W-1:0] dest, input logic [NI-1:0] last);
    bus.i_req  = req;
    bus.i_dest = dest;
    bus.i_last = last;
  endtask

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_own[o] = -1;
      m_ptr[o] = 0;
    end
    m_en = 1'b0;
  endtask

  task automatic model_outputs();
    e_cmd = '0; e_busy = '0; e_grant = '0;
    for (int o = 0; o < NO; o++) begin
      if (m_own[o] >= 0) begin
        e_busy[o] = 1'b1;
        e_cmd[m_own[o]*NO + o] = 1'b1;
        if (bus.i_req[m_own[o]]) e_grant[m_own[o]] = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    model_outputs();
    cmp({tag, "/cmd"},   128'(bus.o_cmd),   128'(e_cmd));
    cmp({tag, "/grant"}, 128'(bus.o_grant), 128'(e_grant));
    cmp({tag, "/busy"},  128'(bus.o_busy),  128'(e_busy));
    cmp({tag, "/en"},    128'(bus.o_en),    128'(m_en));
  endtask

  // One clock of the allocation rules, applied to the inputs currently driven.
  task automatic model_step();
    int  nxt [NO];
    bit  owned [NI];
    bit  found;
    int  j;
    for (int k = 0; k < NI; k++) owned[k] = 1'b0;
    for (int o = 0; o < NO; o++) if (m_own[o] >= 0) owned[m_own[o]] = 1'b1;
    for (int o = 0; o < NO; o++) begin
      nxt[o] = m_own[o];
      if (m_own[o] >= 0) begin
        if (bus.i_req[m_own[o]] && bus.i_last[m_own[o]]) nxt[o] = -1;
      end else begin
        found = 1'b0;
        for (int k = 0; k < NI; k++) begin
          j = (m_ptr[o] + k) % NI;
          if (!found && bus.i_req[j] && !owned[j] &&
              int'(bus.i_dest[j*DEST_W +: DEST_W]) == o) begin
            found = 1'b1;
            nxt[o] = j;
          end
        end
        if (found) m_ptr[o] = (nxt[o] + 1) % NI;
      end
    end
    for (int o = 0; o < NO; o++) m_own[o] = nxt[o];
    m_en = 1'b1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    check_model(tag);
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NI*DEST_W-1:0] dv;
    logic [NI-1:0]        rq, ls;
    int                   cnt;
    bit                   ok;

    drive('0, '0, '0);
    model_reset();

    // Reset state while rst is held.
    #2;
    check_model("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    cyc("en_low");
    for (int i = 0; i < 10; i++) cyc("idle");
    cmp("en_high", 128'(bus.o_en), 128'(1));

    // Table: 4-beat burst from input 3 to output 5, then contention on output 2.
    dv = dpos(3, 5);
    tbl.push_back(mk(16'h0008, dv, 16'h0000, 16'h0000, 8'h00));
    tbl.push_back(mk(16'h0008, dv, 16'h0000, 16'h0008, 8'h20));
    tbl.push_back(mk(16'h0008, dv, 16'h0000, 16'h0008, 8'h20));
    tbl.push_back(mk(16'h0008, dv, 16'h0000, 16'h0008, 8'h20));
    tbl.push_back(mk(16'h0008, dv, 16'h0008, 16'h0008, 8'h20));
    tbl.push_back(mk(16'h0000, dv, 16'h0000, 16'h0000, 8'h00));
    dv = dpos(0, 2) | dpos(7, 2) | dpos(12, 2);
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h0000, 8'h00));
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h0001, 8'h04));
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h0000, 8'h00));
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h0080, 8'h04));
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h0000, 8'h00));
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h1000, 8'h04));
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h0000, 8'h00));
    tbl.push_back(mk(16'h1081, dv, 16'h1081, 16'h0001, 8'h04));
    tbl.push_back(mk(16'h0000, dv, 16'h0000, 16'h0000, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].dest, tbl[i].last);
      @(negedge clk);
      cmp($sformatf("tbl%0d/grant", i), 128'(bus.o_grant), 128'(tbl[i].exp_grant));
      cmp($sformatf("tbl%0d/busy", i),  128'(bus.o_busy),  128'(tbl[i].exp_busy));
      if (i >= 1 && i <= 4) cmp($sformatf("tbl%0d/cmd29", i), 128'(bus.o_cmd[29]), 128'(1));
      check_model($sformatf("tbl%0d", i));
      advance();
    end

    // Parallel routing: inputs 0..7 target outputs 7..0.
    dv = '0;
    for (int j = 0; j < 8; j++) dv |= dpos(j, 7 - j);
    drive(16'h00FF, dv, 16'h0000);
    cyc("par_arb");
    @(negedge clk);
    cmp("par_grant", 128'(bus.o_grant), 128'(16'h00FF));
    cmp("par_ones",  128'($countones(bus.o_cmd)), 128'(8));
    cmp("par_busy",  128'(bus.o_busy), 128'(8'hFF));
    ok = 1'b1;
    for (int o = 0; o < NO; o++) begin
      cnt = 0;
      for (int j = 0; j < NI; j++) if (bus.o_cmd[j*NO + o]) cnt++;
      if (cnt != 1) ok = 1'b0;
    end
    cmp("par_one_owner", 128'(ok), 128'(1));
    check_model("par");
    advance();
    drive(16'h00FF, dv, 16'h00FF);
    cyc("par_last");
    drive('0, dv, '0);
    cyc("par_done");

    // Mid-burst request drop: input 4 owns output 1 while input 9 waits.
    dv = dpos(4, 1) | dpos(9, 1);
    drive(16'h0010, dv, 16'h0000);
    cyc("drop_arb");
    for (int i = 0; i < 2; i++) begin
      drive(16'h0200, dv, 16'h0000);
      @(negedge clk);
      cmp("drop_grant", 128'(bus.o_grant), 128'(16'h0000));
      cmp("drop_busy1", 128'(bus.o_busy[1]), 128'(1));
      check_model("drop");
      advance();
    end
    drive(16'h0210, dv, 16'h0210);
    @(negedge clk);
    cmp("drop_resume", 128'(bus.o_grant), 128'(16'h0010));
    check_model("drop_resume");
    advance();
    @(negedge clk);
    cmp("drop_bubble", 128'(bus.o_grant), 128'(16'h0000));
    check_model("drop_bubble");
    advance();
    @(negedge clk);
    cmp("drop_next", 128'(bus.o_grant), 128'(16'h0200));
    check_model("drop_next");
    advance();
    drive('0, dv, '0);
    cyc("drop_done");

    // Asynchronous reset in the middle of a burst.
    drive(16'h0020, dpos(5, 3), 16'h0000);
    cyc("arst_arb");
    cyc("arst_burst");
    #2 rst = 1'b1;
    #1;
    cmp("arst_cmd",   128'(bus.o_cmd),   128'(0));
    cmp("arst_grant", 128'(bus.o_grant), 128'(0));
    cmp("arst_busy",  128'(bus.o_busy),  128'(0));
    model_reset();
    drive('0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(16'h8004, '0, 16'h8004);
    cyc("arst_rearb");
    @(negedge clk);
    cmp("arst_first", 128'(bus.o_grant), 128'(16'h0004));
    check_model("arst_first");
    advance();
    cyc("arst_bubble");
    @(negedge clk);
    cmp("arst_second", 128'(bus.o_grant), 128'(16'h8000));
    check_model("arst_second");
    advance();
    drive('0, '0, '0);
    cyc("arst_done");

    // Randomized bursts obeying the requester protocol.
    for (int j = 0; j < NI; j++) begin
      r_act[j] = 1'b0; r_dest[j] = 0; r_left[j] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        #2 rst = 1'b1;
        model_reset();
        for (int j = 0; j < NI; j++) r_act[j] = 1'b0;
        drive('0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
      end
      rq = '0; ls = '0; dv = '0;
      for (int j = 0; j < NI; j++) begin
        if (!r_act[j] && ($urandom % 4 == 0)) begin
          r_act[j]  = 1'b1;
          r_dest[j] = $urandom_range(0, NO - 1);
          r_left[j] = $urandom_range(1, 4);
        end
        rq[j] = r_act[j] && ($urandom % 8 != 0);
        ls[j] = r_act[j] && (r_left[j] == 1);
        dv |= dpos(j, r_dest[j]);
      end
      drive(rq, dv, ls);
      @(negedge clk);
      check_model("rand");
      for (int j = 0; j < NI; j++) begin
        if (e_grant[j]) begin
          r_left[j]--;
          if (r_left[j] == 0) r_act[j] = 1'b0;
        end
      end
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
